// File: rtl/extint_controller_v2.sv
// extint_controller_v2: external interrupt controller between SRC_NUM IP
// interrupt lines and the core's single external-interrupt input.
// Per-source pending, enable and edge/level mode; fixed priority (source 0
// highest). Firmware access goes through a 4-register bus slave:
//   0x0 PEND (R/W1C), 0x4 EN (RW), 0x8 MODE (RW, 0=rising edge, 1=level-high),
//   0xC CLAIM (RO, winner index+1 or 0).
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   ext_int_trigger    to core, |(pend & en)
//   ext_int_handled    from core, 1-cycle pulse: current winner serviced
//   ext_int_from       IP interrupt lines, synchronous to clk
//   addr/w_rb/acc/wdata/req  bus request
//   rdata/resp         registered bus response
//   fault              combinational illegal-access flag

`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module extint_controller_v2 #(
  parameter int unsigned SRC_NUM  = 8,
  parameter int unsigned VA_WIDTH = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      ext_int_trigger,
  input  logic                      ext_int_handled,
  input  logic [SRC_NUM-1:0]        ext_int_from,
  input  logic [VA_WIDTH-1:0]       addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [XLEN-1:0]           rdata,
  input  logic [XLEN-1:0]           wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault
);

  localparam int unsigned CLAIM_W = $clog2(SRC_NUM + 1);

  localparam logic [VA_WIDTH-1:0] ADDR_PEND  = VA_WIDTH'(4'h0);
  localparam logic [VA_WIDTH-1:0] ADDR_EN    = VA_WIDTH'(4'h4);
  localparam logic [VA_WIDTH-1:0] ADDR_MODE  = VA_WIDTH'(4'h8);
  localparam logic [VA_WIDTH-1:0] ADDR_CLAIM = VA_WIDTH'(4'hC);

  logic [SRC_NUM-1:0] prev_q, prev_d;
  logic [SRC_NUM-1:0] pend_q, pend_d;
  logic [SRC_NUM-1:0] en_q, en_d;
  logic [SRC_NUM-1:0] mode_q, mode_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               resp_q, resp_d;

  logic [SRC_NUM-1:0] edge_c;
  logic [SRC_NUM-1:0] act_c;
  logic [SRC_NUM-1:0] win_onehot_c;
  logic [SRC_NUM-1:0] w1c_c;
  logic [SRC_NUM-1:0] clr_c;
  logic [CLAIM_W-1:0] win_idx_c;
  logic [CLAIM_W-1:0] claim_c;
  logic               win_vld_c;
  logic               invld_c;
  logic               wr_c;
  logic               rd_c;
  logic               unused_wdata_c;

  // Only the low SRC_NUM write-data bits map to register bits.
  assign unused_wdata_c = ^wdata;

  assign edge_c = ext_int_from & ~prev_q;
  assign act_c  = pend_q & en_q;

  // Fixed priority: scan from the top so the lowest active index wins.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int i = int'(SRC_NUM) - 1; i >= 0; i--) begin
      if (act_c[i]) begin
        win_vld_c = 1'b1;
        win_idx_c = CLAIM_W'(i);
      end
    end
  end

  assign win_onehot_c = win_vld_c ? (SRC_NUM'(1) << win_idx_c) : '0;
  assign claim_c      = win_vld_c ? (win_idx_c + CLAIM_W'(1)) : '0;

  // Bus access decode.
  assign invld_c = (acc != `BUS_ACC_4B) || (addr[1:0] != 2'b00) ||
                   (w_rb && (addr == ADDR_CLAIM));
  assign fault   = req & invld_c;
  assign wr_c    = req & ~invld_c & w_rb;
  assign rd_c    = req & ~invld_c & ~w_rb;

  assign w1c_c = (wr_c && (addr == ADDR_PEND)) ? wdata[SRC_NUM-1:0] : '0;
  assign clr_c = w1c_c | (ext_int_handled ? win_onehot_c : '0);

  // Next-state logic for all registers.
  always_comb begin
    prev_d  = ext_int_from;
    en_d    = en_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    // Level bits mirror the input; edge bits let a new edge win over a clear.
    pend_d  = (mode_q & ext_int_from) |
              (~mode_q & ((pend_q & ~clr_c) | edge_c));

    if (wr_c) begin
      if (addr == ADDR_EN)   en_d   = wdata[SRC_NUM-1:0];
      if (addr == ADDR_MODE) mode_d = wdata[SRC_NUM-1:0];
    end

    if (wr_c || rd_c) begin
      resp_d = 1'b1;
    end

    if (rd_c) begin
      case (addr)
        ADDR_PEND:  rdata_d = XLEN'(pend_q);
        ADDR_EN:    rdata_d = XLEN'(en_q);
        ADDR_MODE:  rdata_d = XLEN'(mode_q);
        ADDR_CLAIM: rdata_d = XLEN'(claim_c);
        default:    rdata_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_q  <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign ext_int_trigger = |act_c;
  assign rdata           = rdata_q;
  assign resp            = resp_q;

endmodule

// File: tb/tb_extint_controller_v2.sv
// Self-checking bench for extint_controller_v2 (SRC_NUM=8, VA_WIDTH=4, XLEN=32).

`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module tb_extint_controller_v2;

  logic                      clk;
  logic                      rstn;
  logic                      ext_int_trigger;
  logic                      ext_int_handled;
  logic [7:0]                ext_int_from;
  logic [3:0]                addr;
  logic                      w_rb;
  logic [`BUS_ACC_WIDTH-1:0] acc;
  logic [31:0]               rdata;
  logic [31:0]               wdata;
  logic                      req;
  logic                      resp;
  logic                      fault;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  logic [1:0]  acc_1b;

  extint_controller_v2 #(.SRC_NUM(8), .VA_WIDTH(4), .XLEN(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ext_int_trigger (ext_int_trigger),
    .ext_int_handled (ext_int_handled),
    .ext_int_from    (ext_int_from),
    .addr            (addr),
    .w_rb            (w_rb),
    .acc             (acc),
    .rdata           (rdata),
    .wdata           (wdata),
    .req             (req),
    .resp            (resp),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_trig(input logic exp, input string name);
    checks++;
    if (ext_int_trigger !== exp) begin
      errors++;
      $display("FAIL %s: trigger got %b want %b", name, ext_int_trigger, exp);
    end
  endtask

  // Legal read: expectation queued at request, popped when resp arrives.
  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    int n;
    addr = a; w_rb = 1'b0; acc = `BUS_ACC_4B; req = 1'b1;
    exp_q.push_back(exp);
    step();
    req = 1'b0;
    n = 0;
    while (resp !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (resp !== 1'b1) begin
      errors++;
      $display("FAIL %s: no resp within bound", name);
      void'(exp_q.pop_front());
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (rdata !== e) begin
        errors++;
        $display("FAIL %s: rdata got 0x%08h want 0x%08h", name, rdata, e);
      end
      last_rdata = e;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input string name);
    addr = a; w_rb = 1'b1; acc = `BUS_ACC_4B; wdata = d; req = 1'b1;
    step();
    req = 1'b0; w_rb = 1'b0;
    checks++;
    if (resp !== 1'b1) begin
      errors++;
      $display("FAIL %s: write resp got %b want 1", name, resp);
    end
  endtask

  // Illegal access: fault same cycle, no resp, rdata held.
  task automatic bad_access(input logic [3:0] a, input logic w, input logic [1:0] ac,
                            input logic [31:0] d, input string name);
    addr = a; w_rb = w; acc = ac; wdata = d; req = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL %s: fault got %b want 1", name, fault);
    end
    step();
    req = 1'b0; w_rb = 1'b0; acc = `BUS_ACC_4B;
    checks++;
    if (resp !== 1'b0 || rdata !== last_rdata) begin
      errors++;
      $display("FAIL %s: resp=%b rdata=0x%08h want resp=0 rdata=0x%08h",
               name, resp, rdata, last_rdata);
    end
  endtask

  task automatic pulse_src(input logic [7:0] m);
    ext_int_from = ext_int_from | m;
    step();
    ext_int_from = ext_int_from & ~m;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++;
    if (ext_int_trigger !== 1'b0 || resp !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: trig=%b resp=%b rdata=0x%08h want 0/0/0",
               ext_int_trigger, resp, rdata);
    end
    rstn = 1'b1;
    last_rdata = 32'h0;
    bus_read(4'h0, 32'h0, "reset_pend");
    bus_read(4'h4, 32'h0, "reset_en");
    bus_read(4'h8, 32'h0, "reset_mode");
    bus_read(4'hC, 32'h0, "reset_claim");
  endtask

  task automatic test_basic();
    bus_write(4'h4, 32'hFF, "basic_en");
    ext_int_from[3] = 1'b1;
    chk_trig(1'b0, "basic_trig_before");
    step();
    ext_int_from[3] = 1'b0;
    chk_trig(1'b1, "basic_trig_after");
    bus_read(4'hC, 32'h4, "basic_claim");
    bus_read(4'h0, 32'h08, "basic_pend");
    bus_write(4'h0, 32'h08, "basic_w1c");
    chk_trig(1'b0, "basic_trig_cleared");
  endtask

  task automatic test_priority();
    pulse_src(8'h24);
    bus_read(4'hC, 32'h3, "prio_claim_2");
    ext_int_handled = 1'b1;
    step();
    ext_int_handled = 1'b0;
    bus_read(4'h0, 32'h20, "prio_pend_after_h1");
    bus_read(4'hC, 32'h6, "prio_claim_5");
    chk_trig(1'b1, "prio_trig_still");
    ext_int_handled = 1'b1;
    step();
    ext_int_handled = 1'b0;
    chk_trig(1'b0, "prio_trig_low");
    bus_read(4'h0, 32'h0, "prio_pend_empty");
    // Handled with no winner must leave state alone.
    ext_int_handled = 1'b1;
    step();
    ext_int_handled = 1'b0;
    bus_read(4'hC, 32'h0, "prio_claim_none");
  endtask

  task automatic test_en_mask();
    bus_write(4'h4, 32'h00, "mask_en0");
    pulse_src(8'h02);
    chk_trig(1'b0, "mask_trig_off");
    bus_read(4'h0, 32'h02, "mask_pend");
    bus_read(4'hC, 32'h0, "mask_claim");
    bus_write(4'h4, 32'h02, "mask_en2");
    chk_trig(1'b1, "mask_trig_on");
    bus_write(4'h0, 32'h02, "mask_w1c");
    chk_trig(1'b0, "mask_trig_clear");
  endtask

  task automatic test_level();
    bus_write(4'h4, 32'hFF, "lvl_en");
    bus_write(4'h8, 32'h01, "lvl_mode");
    bus_read(4'h8, 32'h01, "lvl_mode_rd");
    ext_int_from[0] = 1'b1;
    chk_trig(1'b0, "lvl_trig_lag");
    step();
    chk_trig(1'b1, "lvl_trig_high");
    bus_write(4'h0, 32'h01, "lvl_w1c");
    chk_trig(1'b1, "lvl_w1c_ignored");
    bus_read(4'h0, 32'h01, "lvl_pend_high");
    step();
    ext_int_from[0] = 1'b0;
    chk_trig(1'b1, "lvl_trig_before_fall");
    step();
    chk_trig(1'b0, "lvl_trig_follow_low");
    bus_write(4'h8, 32'h00, "lvl_mode_edge");
    bus_read(4'h0, 32'h00, "lvl_pend_zero");
  endtask

  task automatic test_w1c_race();
    pulse_src(8'h04);
    step();
    ext_int_from[2] = 1'b1;
    bus_write(4'h0, 32'h04, "race_w1c");
    ext_int_from[2] = 1'b0;
    bus_read(4'h0, 32'h04, "race_pend_kept");
    bus_write(4'h0, 32'h04, "race_w1c2");
    bus_read(4'h0, 32'h00, "race_pend_clr");
    // Handled (winner src1) plus W1C of src3 in one cycle: both clear.
    pulse_src(8'h0A);
    ext_int_handled = 1'b1;
    bus_write(4'h0, 32'h08, "race_h_w1c");
    ext_int_handled = 1'b0;
    bus_read(4'h0, 32'h00, "race_both_clr");
  endtask

  task automatic test_fault();
    bus_write(4'h4, 32'h5A, "flt_en");
    pulse_src(8'h10);
    bad_access(4'h4, 1'b0, acc_1b, 32'h0, "flt_read_1b");
    bad_access(4'h2, 1'b0, `BUS_ACC_4B, 32'h0, "flt_unaligned_rd");
    bad_access(4'h6, 1'b1, `BUS_ACC_4B, 32'hFF, "flt_unaligned_wr");
    bad_access(4'hC, 1'b1, `BUS_ACC_4B, 32'hFF, "flt_claim_wr");
    bad_access(4'h0, 1'b1, acc_1b, 32'h10, "flt_w1c_1b");
    addr = 4'h4; w_rb = 1'b0; acc = `BUS_ACC_4B; req = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL flt_legal_nofault: fault got %b want 0", fault);
    end
    req = 1'b0;
    bus_read(4'h4, 32'h5A, "flt_en_kept");
    bus_read(4'h0, 32'h10, "flt_pend_kept");
    // Back-to-back reads.
    bus_read(4'h8, 32'h00, "b2b_mode");
    bus_read(4'hC, 32'h5, "b2b_claim");
  endtask

  task automatic test_reset_mid();
    addr = 4'h4; w_rb = 1'b0; acc = `BUS_ACC_4B; req = 1'b1;
    rstn = 1'b0;
    step();
    req = 1'b0;
    checks++;
    if (resp !== 1'b0 || rdata !== 32'h0 || ext_int_trigger !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: resp=%b rdata=0x%08h trig=%b want 0/0/0",
               resp, rdata, ext_int_trigger);
    end
    rstn = 1'b1;
    last_rdata = 32'h0;
    bus_read(4'h4, 32'h0, "rst_mid_en");
    bus_read(4'h0, 32'h0, "rst_mid_pend");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    acc_1b = 2'b00;
    last_rdata = 32'h0;
    rstn = 1'b0;
    ext_int_handled = 1'b0;
    ext_int_from = 8'h00;
    addr = 4'h0;
    w_rb = 1'b0;
    acc = `BUS_ACC_4B;
    wdata = 32'h0;
    req = 1'b0;

    test_reset();
    test_basic();
    test_priority();
    test_en_mask();
    test_level();
    test_w1c_race();
    test_fault();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
